// File: rtl/operand_collector.sv
//==============================================================================
// Module      : operand_collector
// Description : Single-slot operand collector. Latches one dispatched
//               instruction, reads its required operands from the register
//               file one at a time, then presents the instruction and the
//               collected operand data to the execution units.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package bgpu_pkg;
    typedef logic [31:0] inst_t;
endpackage

module operand_collector
    import bgpu_pkg::*;
#(
    parameter int unsigned NumTags         = 8,
    parameter int unsigned PcWidth         = 32,
    parameter int unsigned WarpWidth       = 32,
    parameter int unsigned RegIdxWidth     = 6,
    parameter int unsigned OperandsPerInst = 2,
    parameter int unsigned DataWidth       = 32
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,

    output logic                                           opc_ready_o,
    input  logic                                           disp_valid_i,
    input  logic [$clog2(NumTags)-1:0]                     disp_tag_i,
    input  logic [PcWidth-1:0]                             disp_pc_i,
    input  logic [WarpWidth-1:0]                           disp_act_mask_i,
    input  inst_t                                          disp_inst_i,
    input  logic [RegIdxWidth-1:0]                         disp_dst_i,
    input  logic [OperandsPerInst-1:0]                     disp_operands_required_i,
    input  logic [OperandsPerInst*RegIdxWidth-1:0]         disp_operands_i,

    output logic                                           rf_req_valid_o,
    input  logic                                           rf_req_ready_i,
    output logic [RegIdxWidth-1:0]                         rf_req_reg_o,
    input  logic                                           rf_rsp_valid_i,
    input  logic [WarpWidth*DataWidth-1:0]                 rf_rsp_data_i,

    output logic                                           eu_valid_o,
    input  logic                                           eu_ready_i,
    output logic [$clog2(NumTags)-1:0]                     eu_tag_o,
    output logic [PcWidth-1:0]                             eu_pc_o,
    output logic [WarpWidth-1:0]                           eu_act_mask_o,
    output inst_t                                          eu_inst_o,
    output logic [RegIdxWidth-1:0]                         eu_dst_o,
    output logic [OperandsPerInst*WarpWidth*DataWidth-1:0] eu_operands_o
);

    localparam int unsigned TAG_WIDTH = $clog2(NumTags);
    localparam int unsigned OP_WIDTH  = WarpWidth * DataWidth;
    localparam int unsigned IDX_WIDTH = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ISSUE = 2'd3;

    logic [1:0]                                    state;
    logic [1:0]                                    next_state;
    logic [IDX_WIDTH-1:0]                          idx;

    logic [TAG_WIDTH-1:0]                          tag;
    logic [PcWidth-1:0]                            pc;
    logic [WarpWidth-1:0]                          act_mask;
    inst_t                                         inst;
    logic [RegIdxWidth-1:0]                        dst;
    logic [OperandsPerInst-1:0]                    required;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0]   operands;
    logic [OperandsPerInst-1:0][OP_WIDTH-1:0]      operand_data;

    logic                                          first_found;
    logic [IDX_WIDTH-1:0]                          first_idx;
    logic                                          next_found;
    logic [IDX_WIDTH-1:0]                          next_idx;

    // Lowest required operand of the incoming instruction, and the next
    // required operand above the one currently being collected.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = OperandsPerInst - 1; i >= 0; i--) begin
            if (disp_operands_required_i[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_WIDTH'(i);
            end
            if (required[i] && (i > int'(idx))) begin
                next_found = 1'b1;
                next_idx   = IDX_WIDTH'(i);
            end
        end
    end

    // State register; reset abandons any in-flight register read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one request outstanding at a time, ascending order.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (disp_valid_i)   next_state = first_found ? ST_REQ : ST_ISSUE;
            ST_REQ:   if (rf_req_ready_i) next_state = ST_WAIT;
            ST_WAIT:  if (rf_rsp_valid_i) next_state = next_found ? ST_REQ : ST_ISSUE;
            ST_ISSUE: if (eu_ready_i)     next_state = ST_IDLE;
            default:                      next_state = ST_IDLE;
        endcase
    end

    // Instruction latch and operand capture; unrequested operands stay zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx          <= '0;
            tag          <= '0;
            pc           <= '0;
            act_mask     <= '0;
            inst         <= '0;
            dst          <= '0;
            required     <= '0;
            operands     <= '0;
            operand_data <= '0;
        end else begin
            if (state == ST_IDLE && disp_valid_i) begin
                idx          <= first_idx;
                tag          <= disp_tag_i;
                pc           <= disp_pc_i;
                act_mask     <= disp_act_mask_i;
                inst         <= disp_inst_i;
                dst          <= disp_dst_i;
                required     <= disp_operands_required_i;
                operands     <= disp_operands_i;
                operand_data <= '0;
            end else if (state == ST_WAIT && rf_rsp_valid_i) begin
                operand_data[idx] <= rf_rsp_data_i;
                if (next_found) begin
                    idx <= next_idx;
                end
            end
        end
    end

    // Handshake outputs decoded from state; data outputs come from the latch.
    always_comb begin
        opc_ready_o    = (state == ST_IDLE);
        rf_req_valid_o = (state == ST_REQ);
        eu_valid_o     = (state == ST_ISSUE);
        rf_req_reg_o   = operands[idx];
        eu_tag_o       = tag;
        eu_pc_o        = pc;
        eu_act_mask_o  = act_mask;
        eu_inst_o      = inst;
        eu_dst_o       = dst;
        eu_operands_o  = operand_data;
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rf_req_valid_o && !rf_req_ready_i) |=> (rf_req_valid_o && $stable(rf_req_reg_o)));

    a_eu_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (eu_valid_o && !eu_ready_i) |=> (eu_valid_o && $stable(eu_tag_o) && $stable(eu_pc_o)
            && $stable(eu_act_mask_o) && $stable(eu_inst_o) && $stable(eu_dst_o)
            && $stable(eu_operands_o)));

    a_rsp_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        rf_rsp_valid_i |-> (state == ST_WAIT));

    a_disp_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (disp_valid_i && !opc_ready_o) |=> disp_valid_i);

endmodule

`default_nettype wire

// File: tb/tb_operand_collector.sv
//==============================================================================
// Module      : tb_operand_collector
// Description : Directed self-checking bench for operand_collector with a
//               queue-based scoreboard of expected issued instructions.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_operand_collector;

    localparam int W = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            opc_ready_o;
    logic            disp_valid_i = 1'b0;
    logic [2:0]      disp_tag_i = '0;
    logic [31:0]     disp_pc_i = '0;
    logic [31:0]     disp_act_mask_i = '0;
    logic [31:0]     disp_inst_i = '0;
    logic [5:0]      disp_dst_i = '0;
    logic [1:0]      disp_operands_required_i = '0;
    logic [11:0]     disp_operands_i = '0;
    logic            rf_req_valid_o;
    logic            rf_req_ready_i = 1'b0;
    logic [5:0]      rf_req_reg_o;
    logic            rf_rsp_valid_i = 1'b0;
    logic [W-1:0]    rf_rsp_data_i = '0;
    logic            eu_valid_o;
    logic            eu_ready_i = 1'b0;
    logic [2:0]      eu_tag_o;
    logic [31:0]     eu_pc_o;
    logic [31:0]     eu_act_mask_o;
    logic [31:0]     eu_inst_o;
    logic [5:0]      eu_dst_o;
    logic [2*W-1:0]  eu_operands_o;

    typedef struct {
        logic [2:0]   tag;
        logic [31:0]  pc;
        logic [31:0]  mask;
        logic [31:0]  inst;
        logic [5:0]   dst;
        logic [W-1:0] op0;
        logic [W-1:0] op1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   req_seen = 0;
    logic ready_default = 1'b0;

    operand_collector dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .opc_ready_o              (opc_ready_o),
        .disp_valid_i             (disp_valid_i),
        .disp_tag_i               (disp_tag_i),
        .disp_pc_i                (disp_pc_i),
        .disp_act_mask_i          (disp_act_mask_i),
        .disp_inst_i              (disp_inst_i),
        .disp_dst_i               (disp_dst_i),
        .disp_operands_required_i (disp_operands_required_i),
        .disp_operands_i          (disp_operands_i),
        .rf_req_valid_o           (rf_req_valid_o),
        .rf_req_ready_i           (rf_req_ready_i),
        .rf_req_reg_o             (rf_req_reg_o),
        .rf_rsp_valid_i           (rf_rsp_valid_i),
        .rf_rsp_data_i            (rf_rsp_data_i),
        .eu_valid_o               (eu_valid_o),
        .eu_ready_i               (eu_ready_i),
        .eu_tag_o                 (eu_tag_o),
        .eu_pc_o                  (eu_pc_o),
        .eu_act_mask_o            (eu_act_mask_o),
        .eu_inst_o                (eu_inst_o),
        .eu_dst_o                 (eu_dst_o),
        .eu_operands_o            (eu_operands_o)
    );

    always #5 clk = ~clk;

    // Count register-file request handshakes, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && rf_req_valid_o && rf_req_ready_i) req_seen++;
    end

    function automatic logic [W-1:0] fill(input logic [31:0] w);
        fill = {32{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed hi/lo %h/%h expected hi/lo %h/%h", name,
                   obs[W-1:W-64], obs[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    task automatic check_fields(input exp_t e);
        chk("eu_tag", 64'(eu_tag_o), 64'(e.tag));
        chk("eu_pc", 64'(eu_pc_o), 64'(e.pc));
        chk("eu_act_mask", 64'(eu_act_mask_o), 64'(e.mask));
        chk("eu_inst", 64'(eu_inst_o), 64'(e.inst));
        chk("eu_dst", 64'(eu_dst_o), 64'(e.dst));
        chk_wide("eu_operand0", eu_operands_o[W-1:0], e.op0);
        chk_wide("eu_operand1", eu_operands_o[2*W-1:W], e.op1);
    endtask

    task automatic dispatch(input bit push, input logic [2:0] tag, input logic [31:0] pc,
                            input logic [31:0] mask, input logic [31:0] inst, input logic [5:0] dst,
                            input logic [1:0] req, input logic [5:0] r0, input logic [5:0] r1,
                            input logic [W-1:0] d0, input logic [W-1:0] d1, output int acc_cyc);
        exp_t e;
        int   n = 0;
        disp_tag_i = tag;
        disp_pc_i = pc;
        disp_act_mask_i = mask;
        disp_inst_i = inst;
        disp_dst_i = dst;
        disp_operands_required_i = req;
        disp_operands_i = {r1, r0};
        disp_valid_i = 1'b1;
        while (!opc_ready_o && n < 50) begin
            step();
            n++;
        end
        chk("disp_accept_ready", 64'(opc_ready_o), 64'd1);
        acc_cyc = cyc;
        step();
        disp_valid_i = 1'b0;
        if (push) begin
            e.tag = tag;
            e.pc = pc;
            e.mask = mask;
            e.inst = inst;
            e.dst = dst;
            e.op0 = req[0] ? d0 : '0;
            e.op1 = req[1] ? d1 : '0;
            sb.push_back(e);
        end
    endtask

    task automatic rf_serve(input logic [5:0] reg_exp, input logic [W-1:0] data, input int stall);
        int n = 0;
        while (!rf_req_valid_o && n < 50) begin
            step();
            n++;
        end
        chk("rf_req_valid", 64'(rf_req_valid_o), 64'd1);
        chk("rf_req_reg", 64'(rf_req_reg_o), 64'(reg_exp));
        if (stall > 0) begin
            rf_req_ready_i = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                chk("rf_req_valid_held", 64'(rf_req_valid_o), 64'd1);
                chk("rf_req_reg_held", 64'(rf_req_reg_o), 64'(reg_exp));
            end
        end
        rf_req_ready_i = 1'b1;
        step();
        rf_req_ready_i = ready_default;
        rf_rsp_valid_i = 1'b1;
        rf_rsp_data_i = data;
        step();
        rf_rsp_valid_i = 1'b0;
        rf_rsp_data_i = '0;
    endtask

    task automatic eu_collect(input int acc_cyc, input int exp_lat, input int stall);
        exp_t e;
        int   n = 0;
        while (!eu_valid_o && n < 50) begin
            step();
            n++;
        end
        chk("eu_valid", 64'(eu_valid_o), 64'd1);
        if (exp_lat >= 0) chk("eu_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        chk("scoreboard_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_fields(e);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("eu_valid_held", 64'(eu_valid_o), 64'd1);
            chk("opc_ready_busy", 64'(opc_ready_o), 64'd0);
            check_fields(e);
        end
        eu_ready_i = 1'b1;
        step();
        eu_ready_i = 1'b0;
        chk("eu_valid_drop", 64'(eu_valid_o), 64'd0);
        chk("opc_ready_after_issue", 64'(opc_ready_o), 64'd1);
    endtask

    initial begin
        int acc;
        int r;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_opc_ready", 64'(opc_ready_o), 64'd1);
        chk("rst_rf_req_valid", 64'(rf_req_valid_o), 64'd0);
        chk("rst_eu_valid", 64'(eu_valid_o), 64'd0);
        chk("rst_rf_req_reg", 64'(rf_req_reg_o), 64'd0);
        chk("rst_eu_tag", 64'(eu_tag_o), 64'd0);
        chk("rst_eu_pc", 64'(eu_pc_o), 64'd0);
        chk_wide("rst_eu_op0", eu_operands_o[W-1:0], '0);
        chk_wide("rst_eu_op1", eu_operands_o[2*W-1:W], '0);
        rst = 1'b0;
        step();
        chk("idle_opc_ready", 64'(opc_ready_o), 64'd1);

        // No operands: issue one cycle after accept, no RF traffic
        r = req_seen;
        dispatch(1'b1, 3'd3, 32'h0000_1000, 32'hFFFF_FFFF, 32'h1234_5678, 6'd4,
                 2'b00, 6'd1, 6'd2, '0, '0, acc);
        eu_collect(acc, 1, 0);
        chk("no_op_requests", 64'(req_seen - r), 64'd0);

        // Two operands, RF always ready: reg 5 then reg 9, issue at accept+5
        ready_default = 1'b1;
        rf_req_ready_i = 1'b1;
        r = req_seen;
        dispatch(1'b1, 3'd1, 32'h0000_2000, 32'h0F0F_0F0F, 32'hCAFE_0001, 6'd10,
                 2'b11, 6'd5, 6'd9, fill(32'hAAAA_AAAA), fill(32'hBBBB_BBBB), acc);
        rf_serve(6'd5, fill(32'hAAAA_AAAA), 0);
        rf_serve(6'd9, fill(32'hBBBB_BBBB), 0);
        eu_collect(acc, 5, 0);
        chk("two_op_requests", 64'(req_seen - r), 64'd2);

        // Only operand 1 required: single request for reg 12, operand 0 cleared
        r = req_seen;
        dispatch(1'b1, 3'd2, 32'h0000_3000, 32'h0000_00FF, 32'hCAFE_0002, 6'd11,
                 2'b10, 6'd7, 6'd12, fill(32'h1357_9BDF), fill(32'hCCCC_CCCC), acc);
        rf_serve(6'd12, fill(32'hCCCC_CCCC), 0);
        eu_collect(acc, 3, 0);
        chk("one_op_requests", 64'(req_seen - r), 64'd1);

        // RF backpressure 3 cycles, EU backpressure 4 cycles with a pending dispatch
        ready_default = 1'b0;
        rf_req_ready_i = 1'b0;
        dispatch(1'b1, 3'd5, 32'h0000_4000, 32'h8000_0001, 32'hCAFE_0003, 6'd33,
                 2'b01, 6'd33, 6'd0, fill(32'hDEAD_BEEF), '0, acc);
        rf_serve(6'd33, fill(32'hDEAD_BEEF), 3);
        disp_tag_i = 3'd6;
        disp_pc_i = 32'h0000_5000;
        disp_act_mask_i = 32'h0000_0003;
        disp_inst_i = 32'hCAFE_0004;
        disp_dst_i = 6'd2;
        disp_operands_required_i = 2'b00;
        disp_operands_i = '0;
        disp_valid_i = 1'b1;
        eu_collect(acc, -1, 4);
        dispatch(1'b1, 3'd6, 32'h0000_5000, 32'h0000_0003, 32'hCAFE_0004, 6'd2,
                 2'b00, 6'd0, 6'd0, '0, '0, acc);
        eu_collect(acc, 1, 0);

        // Reset while waiting for a response; a late response is ignored
        dispatch(1'b0, 3'd2, 32'h0000_6000, 32'h0000_FFFF, 32'hCAFE_0005, 6'd20,
                 2'b01, 6'd20, 6'd0, '0, '0, acc);
        begin
            int n = 0;
            while (!rf_req_valid_o && n < 50) begin
                step();
                n++;
            end
        end
        chk("rw_req_reg", 64'(rf_req_reg_o), 64'd20);
        rf_req_ready_i = 1'b1;
        step();
        rf_req_ready_i = 1'b0;
        chk("rw_in_wait", 64'(opc_ready_o), 64'd0);
        rst = 1'b1;
        #1;
        chk("rw_opc_ready", 64'(opc_ready_o), 64'd1);
        chk("rw_rf_req_valid", 64'(rf_req_valid_o), 64'd0);
        chk("rw_eu_valid", 64'(eu_valid_o), 64'd0);
        chk("rw_eu_tag", 64'(eu_tag_o), 64'd0);
        chk("rw_eu_pc", 64'(eu_pc_o), 64'd0);
        chk("rw_eu_dst", 64'(eu_dst_o), 64'd0);
        chk("rw_rf_req_reg", 64'(rf_req_reg_o), 64'd0);
        rf_rsp_valid_i = 1'b1;
        rf_rsp_data_i = fill(32'hDDDD_DDDD);
        step();
        rf_rsp_valid_i = 1'b0;
        rf_rsp_data_i = '0;
        rst = 1'b0;
        step();
        step();
        chk_wide("rw_op0_zero", eu_operands_o[W-1:0], '0);
        chk_wide("rw_op1_zero", eu_operands_o[2*W-1:W], '0);
        chk("rw_idle_ready", 64'(opc_ready_o), 64'd1);
        chk("rw_eu_valid_after", 64'(eu_valid_o), 64'd0);

        // Recovery: both operands with a one-cycle RF stall on the second
        r = req_seen;
        dispatch(1'b1, 3'd7, 32'h0000_7000, 32'h5555_5555, 32'hCAFE_0006, 6'd63,
                 2'b11, 6'd1, 6'd62, fill(32'h1111_1111), fill(32'h2222_2222), acc);
        rf_serve(6'd1, fill(32'h1111_1111), 0);
        rf_serve(6'd62, fill(32'h2222_2222), 1);
        eu_collect(acc, -1, 0);
        chk("recovery_requests", 64'(req_seen - r), 64'd2);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
